// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default address width, reset vector and sequencer FSM states.
package cpu_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam logic [ADDR_W-1:0] RESET_VECTOR = 16'h0000;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    EXEC
  } state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch/execute control bundle between the decode/memory side and the PC sequencer.
interface pc_sequencer_if #(
  parameter int unsigned ADDR_W = cpu_pkg::ADDR_W
);

  logic              Dcondn;
  logic              is_branch;
  logic              is_jump;
  logic [8:0]        IR8_0;
  logic [ADDR_W-1:0] jump_target;
  logic              stall;
  logic              imem_ack;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              instr_valid;
  logic [ADDR_W-1:0] PC;
  logic              branch_taken;
  logic [15:0]       taken_count;

  modport master (
    output Dcondn, is_branch, is_jump, IR8_0, jump_target, stall, imem_ack,
    input  imem_req, imem_addr, instr_valid, PC, branch_taken, taken_count
  );

  modport slave (
    input  Dcondn, is_branch, is_jump, IR8_0, jump_target, stall, imem_ack,
    output imem_req, imem_addr, instr_valid, PC, branch_taken, taken_count
  );

endinterface

// File: rtl/pc_target_calc.sv
// Combinational next-PC selection: absolute jump, taken PC-relative branch, or sequential.
module pc_target_calc #(
  parameter int unsigned ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              is_jump_i,
  input  logic              is_branch_i,
  input  logic              dcondn_i,
  input  logic [8:0]        offset_i,
  input  logic [ADDR_W-1:0] jump_target_i,
  output logic [ADDR_W-1:0] next_pc_o,
  output logic              taken_o
);

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] offset_sext;

  assign pc_inc      = pc_i + ADDR_W'(1);
  assign offset_sext = {{(ADDR_W - 9){offset_i[8]}}, offset_i};

  // Jump outranks branch; arithmetic wraps naturally at ADDR_W bits.
  always_comb begin
    next_pc_o = pc_inc;
    taken_o   = 1'b0;
    if (is_jump_i) begin
      next_pc_o = jump_target_i;
      taken_o   = 1'b1;
    end else if (is_branch_i && dcondn_i) begin
      next_pc_o = pc_inc + offset_sext;
      taken_o   = 1'b1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: BOOT -> FETCH -> EXEC loop with stall, branch/jump and taken counter.
module pc_sequencer
  import cpu_pkg::state_e;
  import cpu_pkg::BOOT;
  import cpu_pkg::FETCH;
  import cpu_pkg::EXEC;
#(
  parameter int unsigned       ADDR_W       = cpu_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = cpu_pkg::RESET_VECTOR
) (
  input logic            clk,
  input logic            rst_n,
  pc_sequencer_if.slave  bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              taken_q, taken_d;
  logic [15:0]       count_q, count_d;

  logic [ADDR_W-1:0] next_pc;
  logic              target_taken;

  pc_target_calc #(
    .ADDR_W (ADDR_W)
  ) u_target (
    .pc_i          (pc_q),
    .is_jump_i     (bus.is_jump),
    .is_branch_i   (bus.is_branch),
    .dcondn_i      (bus.Dcondn),
    .offset_i      (bus.IR8_0),
    .jump_target_i (bus.jump_target),
    .next_pc_o     (next_pc),
    .taken_o       (target_taken)
  );

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    taken_d         = 1'b0;
    count_d         = count_q;
    bus.imem_req    = 1'b0;
    bus.instr_valid = 1'b0;
    unique case (state_q)
      BOOT: begin
        state_d = FETCH;
      end
      FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ack) begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        bus.instr_valid = 1'b1;
        // Control inputs only matter on the cycle the instruction retires.
        if (!bus.stall) begin
          state_d = FETCH;
          pc_d    = next_pc;
          if (target_taken) begin
            taken_d = 1'b1;
            if (count_q != 16'hFFFF) begin
              count_d = count_q + 16'd1;
            end
          end
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      taken_q <= 1'b0;
      count_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      taken_q <= taken_d;
      count_q <= count_d;
    end
  end

  assign bus.PC           = pc_q;
  assign bus.imem_addr    = pc_q;
  assign bus.branch_taken = taken_q;
  assign bus.taken_count  = count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset timing, next-PC table, stall/wait-state and reset aborts.
module tb_pc_sequencer;

  logic clk;
  logic rst_n;

  pc_sequencer_if #(.ADDR_W(16)) bus ();

  pc_sequencer #(
    .ADDR_W       (16),
    .RESET_VECTOR (16'h0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        j;
    logic        b;
    logic        c;
    logic [8:0]  off;
    logic [15:0] tgt;
    logic [15:0] exp_pc;
    logic        exp_bt;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[13];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    bus.is_jump     = 1'b0;
    bus.is_branch   = 1'b0;
    bus.Dcondn      = 1'b0;
    bus.IR8_0       = 9'h000;
    bus.jump_target = 16'h0000;
    bus.stall       = 1'b0;
  endtask

  // Entered in FETCH; leaves in FETCH with ack low after one retired instruction.
  task automatic run_vec(input vec_t v);
    bus.imem_ack = 1'b1;
    tick();
    chk("exec_valid", {31'd0, bus.instr_valid}, 32'd1);
    bus.imem_ack    = 1'b0;
    bus.is_jump     = v.j;
    bus.is_branch   = v.b;
    bus.Dcondn      = v.c;
    bus.IR8_0       = v.off;
    bus.jump_target = v.tgt;
    tick();
    clear_ctrl();
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 9'h000, 16'h0000, 16'h0001, 1'b0, 16'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 9'h000, 16'h0010, 16'h0010, 1'b1, 16'd1};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 9'h1F0, 16'h0000, 16'h0001, 1'b1, 16'd2};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 9'h000, 16'h0010, 16'h0010, 1'b1, 16'd3};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 9'h1F0, 16'h0000, 16'h0011, 1'b0, 16'd3};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 9'h1F0, 16'hABCD, 16'hABCD, 1'b1, 16'd4};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 9'h0FF, 16'h0000, 16'hACCD, 1'b1, 16'd5};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 9'h0FF, 16'h1111, 16'hACCE, 1'b0, 16'd5};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 9'h000, 16'hFFF8, 16'hFFF8, 1'b1, 16'd6};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 9'h00F, 16'h0000, 16'h0008, 1'b1, 16'd7};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 9'h000, 16'h0003, 16'h0003, 1'b1, 16'd8};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 9'h1F0, 16'h0000, 16'hFFF4, 1'b1, 16'd9};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 9'h000, 16'hFFFF, 16'hFFFF, 1'b1, 16'd10};

    clear_ctrl();
    bus.imem_ack = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_req",   {31'd0, bus.imem_req},     32'd0);
    chk("rst_valid", {31'd0, bus.instr_valid},  32'd0);
    chk("rst_pc",    {16'd0, bus.PC},           32'h0000);
    chk("rst_bt",    {31'd0, bus.branch_taken}, 32'd0);
    chk("rst_cnt",   {16'd0, bus.taken_count},  32'd0);
    tick();
    chk("rst_hold_req", {31'd0, bus.imem_req}, 32'd0);

    // Reset release with ack tied high: fetches at 0000, 0001, 0002 two cycles apart.
    #2 rst_n = 1'b1;
    bus.imem_ack = 1'b1;
    chk("boot_req", {31'd0, bus.imem_req}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("seq_req",  {31'd0, bus.imem_req},  32'd1);
      chk("seq_addr", {16'd0, bus.imem_addr}, i);
      tick();
      chk("seq_exec", {31'd0, bus.instr_valid}, 32'd1);
      chk("seq_noreq", {31'd0, bus.imem_req}, 32'd0);
    end

    bus.imem_ack = 1'b0;
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    chk("rerst_fetch", {31'd0, bus.imem_req}, 32'd1);

    for (int i = 0; i < 13; i++) begin
      run_vec(vecs[i]);
      chk($sformatf("vec%0d_pc", i),  {16'd0, bus.PC},           {16'd0, vecs[i].exp_pc});
      chk($sformatf("vec%0d_bt", i),  {31'd0, bus.branch_taken}, {31'd0, vecs[i].exp_bt});
      chk($sformatf("vec%0d_cnt", i), {16'd0, bus.taken_count},  {16'd0, vecs[i].exp_cnt});
    end

    // PC=FFFF: branch_taken pulse ends, stall holds PC, then wrap to 0000.
    bus.imem_ack = 1'b1;
    tick();
    chk("bt_pulse_end", {31'd0, bus.branch_taken}, 32'd0);
    bus.imem_ack    = 1'b0;
    bus.stall       = 1'b1;
    bus.is_jump     = 1'b1;
    bus.jump_target = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc",    {16'd0, bus.PC},          32'hFFFF);
      chk("stall_valid", {31'd0, bus.instr_valid}, 32'd1);
      chk("stall_cnt",   {16'd0, bus.taken_count}, 32'd10);
    end
    clear_ctrl();
    tick();
    chk("wrap_pc",  {16'd0, bus.PC},           32'h0000);
    chk("wrap_bt",  {31'd0, bus.branch_taken}, 32'd0);
    chk("wrap_cnt", {16'd0, bus.taken_count},  32'd10);
    bus.is_jump     = 1'b1;
    bus.is_branch   = 1'b1;
    bus.Dcondn      = 1'b1;
    bus.jump_target = 16'h5555;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wait_req", {31'd0, bus.imem_req}, 32'd1);
      chk("wait_pc",  {16'd0, bus.PC},       32'h0000);
    end
    clear_ctrl();
    bus.imem_ack = 1'b1;
    tick();
    chk("wait_exec", {31'd0, bus.instr_valid}, 32'd1);
    bus.imem_ack = 1'b0;
    tick();
    chk("wait_next_pc", {16'd0, bus.PC}, 32'h0001);

    // Asynchronous reset mid-FETCH at PC=0042.
    run_vec('{1'b1, 1'b0, 1'b0, 9'h000, 16'h0042, 16'h0042, 1'b1, 16'd11});
    chk("pre_abort_pc", {16'd0, bus.PC}, 32'h0042);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_req", {31'd0, bus.imem_req},     32'd0);
    chk("abort_pc",  {16'd0, bus.PC},           32'h0000);
    chk("abort_cnt", {16'd0, bus.taken_count},  32'd0);
    chk("abort_bt",  {31'd0, bus.branch_taken}, 32'd0);
    #2 rst_n = 1'b1;
    tick();
    chk("post_abort_addr", {16'd0, bus.imem_addr}, 32'h0000);

    // Reset during EXEC with a jump pending leaves no trace.
    bus.imem_ack = 1'b1;
    tick();
    bus.imem_ack    = 1'b0;
    bus.is_jump     = 1'b1;
    bus.jump_target = 16'h5555;
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    clear_ctrl();
    chk("exec_abort_pc",  {16'd0, bus.PC},          32'h0000);
    chk("exec_abort_cnt", {16'd0, bus.taken_count}, 32'd0);
    chk("exec_abort_req", {31'd0, bus.imem_req},    32'd1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 16'h0000: PC value loaded on reset.
REQ-002 Parameter ADDR_W, default 16: width of PC, addresses and jump target.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Dcondn  input  1  branch condition result from the condition-select mux; sampled in EXEC only.
REQ-006 is_branch  input  1  current instruction is a conditional/unconditional PC-relative branch.
REQ-007 is_jump  input  1  current instruction is an absolute jump.
REQ-008 IR8_0  input  9  signed PC-relative branch offset, two's complement.
REQ-009 jump_target  input  ADDR_W  absolute jump address.
REQ-010 stall  input  1  hold the current instruction in EXEC.
REQ-011 imem_ack  input  1  instruction memory has returned the word for imem_addr.
REQ-012 imem_req  output  1  instruction fetch request.
REQ-013 imem_addr  output  ADDR_W  fetch address; always equal to PC.
REQ-014 instr_valid  output  1  fetched instruction is present and executing.
REQ-015 PC  output  ADDR_W  current program counter.
REQ-016 branch_taken  output  1  registered pulse: the last EXEC retired a taken branch or jump.
REQ-017 taken_count  output  16  saturating count of taken branches and jumps.

Function
REQ-018 FSM states: BOOT, FETCH, EXEC.
REQ-019 BOOT: all outputs inactive; transitions to FETCH on the next edge.
REQ-020 FETCH: imem_req=1; stays in FETCH until imem_ack=1, then moves to EXEC on that edge.
REQ-021 EXEC: instr_valid=1 and imem_req=0; stays in EXEC while stall=1, otherwise updates PC and moves to FETCH.
REQ-022 Next PC priority: is_jump gives jump_target; else is_branch&Dcondn gives PC+1+sext(IR8_0); else PC+1.
REQ-023 All PC arithmetic is modulo 2^ADDR_W; increment from 16'hFFFF wraps to 16'h0000; negative offsets wrap below 0.
REQ-024 is_jump and is_branch asserted together: the jump wins; this counts as one taken event.
REQ-025 branch_taken is 1 for exactly one cycle, the cycle after a non-stalled EXEC retires a taken event; otherwise 0.
REQ-026 taken_count increments by 1 per taken event and saturates at 16'hFFFF.
REQ-027 Dcondn, is_branch, is_jump, IR8_0 and jump_target are ignored outside EXEC and while stall=1.
REQ-028 imem_ack outside FETCH is ignored.
REQ-029 Fetch-to-fetch latency without wait states or stall: 2 cycles (FETCH, EXEC).

Reset
REQ-030 rst_n=0 immediately forces state=BOOT, PC=RESET_VECTOR, imem_req=0, instr_valid=0, branch_taken=0 and taken_count=0, independent of clk.
REQ-031 Reset asserted during FETCH or EXEC aborts the operation; no PC update or count from the aborted instruction survives.
REQ-032 After rst_n deasserts, the first imem_req occurs at the second rising edge, with imem_addr=RESET_VECTOR.

Structure
REQ-033 The shared package cpu_pkg holds ADDR_W, the default RESET_VECTOR and the FSM state enum (BOOT, FETCH, EXEC).
REQ-034 One combinational sub-module, pc_target_calc, computes the next PC from PC, the control signals and the offset; the FSM and registers live in pc_sequencer.

Verification
REQ-035 Reset release with imem_ack tied high: stimulus -> imem_addr sequence is 0000, 0001, 0002, with 2 cycles per instruction.
REQ-036 At PC=0010 with is_branch=1, Dcondn=1 and IR8_0=9'h1F0 (-16): stimulus -> next PC=0001, branch_taken pulses once, taken_count=1.
REQ-037 Same case as REQ-036 but Dcondn=0: stimulus -> next PC=0011, branch_taken stays 0, taken_count is unchanged.
REQ-038 is_jump=1 with jump_target=ABCD and is_branch=1, Dcondn=1 together: stimulus -> next PC=ABCD and taken_count increments by exactly 1.
REQ-039 PC=FFFF with no branch; then stall=1 held for 3 cycles in EXEC; then imem_ack delayed 4 cycles: stimulus -> PC holds FFFF during the stall, then wraps to 0000; imem_req stays high for the 4 wait cycles.
REQ-040 rst_n pulsed low mid-FETCH at PC=0042: stimulus -> imem_req drops with no clock edge, PC=RESET_VECTOR, taken_count=0.
